// File: rtl/boss_pkg.sv
// Shared boss definitions: state encoding and default geometry, also used by
// the boss sprite stage and the bullet manager.
package boss_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DYING  = 2'd2,
    DEAD   = 2'd3
  } boss_state_t;

  localparam int COORD_W    = 10;
  localparam int ID_W       = 4;
  localparam int HP_W       = 8;
  localparam int TCNT_W     = 8;

  localparam int BOSS_W_DEF = 50;
  localparam int BOSS_H_DEF = 50;
  localparam int BUL_W_DEF  = 4;
  localparam int BUL_H_DEF  = 8;

endpackage

// File: rtl/boss_hit_detect.sv
// Bullet box vs boss box overlap. Coordinates are widened by one bit so that
// box right/bottom edges near the playfield limit cannot wrap. Touching edges
// do not count as overlap.
module boss_hit_detect
  import boss_pkg::*;
#(
  parameter int BOSS_W = BOSS_W_DEF,
  parameter int BOSS_H = BOSS_H_DEF,
  parameter int BUL_W  = BUL_W_DEF,
  parameter int BUL_H  = BUL_H_DEF
) (
  input  logic [COORD_W-1:0] boss_x_i,
  input  logic [COORD_W-1:0] boss_y_i,
  input  logic [COORD_W-1:0] bul_x_i,
  input  logic [COORD_W-1:0] bul_y_i,
  output logic               overlap_o
);

  localparam int XW = COORD_W + 1;

  logic [XW-1:0] bsx, bsy, bux, buy;

  assign bsx = {1'b0, boss_x_i};
  assign bsy = {1'b0, boss_y_i};
  assign bux = {1'b0, bul_x_i};
  assign buy = {1'b0, bul_y_i};

  assign overlap_o = (bux + XW'(BUL_W) > bsx) && (bux < bsx + XW'(BOSS_W)) &&
                     (buy + XW'(BUL_H) > bsy) && (buy < bsy + XW'(BOSS_H));

endmodule

// File: rtl/boss_hp_ctrl.sv
// Boss health and hit resolution. Resolves presented bullets into damage and
// sequences the boss stage through death and respawn, paced by move_tick.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   ALIVE  | vulnerable; an overlapping bullet costs one hp
//   INVULN | post-hit grace; bullets consumed without damage, blink active
//   DYING  | explosion shown (boom), DEATH_TICKS ticks
//   DEAD   | still boom, RESPAWN_TICKS ticks, then revive with full hp
module boss_hp_ctrl
  import boss_pkg::*;
#(
  parameter int BOSS_W        = BOSS_W_DEF,
  parameter int BOSS_H        = BOSS_H_DEF,
  parameter int BUL_W         = BUL_W_DEF,
  parameter int BUL_H         = BUL_H_DEF,
  parameter int HP_MAX        = 10,
  parameter int INVULN_TICKS  = 8,
  parameter int DEATH_TICKS   = 64,
  parameter int RESPAWN_TICKS = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_tick_i,
  input  logic [COORD_W-1:0] boss_x_i,
  input  logic [COORD_W-1:0] boss_y_i,
  input  logic               bul_valid_i,
  input  logic [ID_W-1:0]    bul_id_i,
  input  logic [COORD_W-1:0] bul_x_i,
  input  logic [COORD_W-1:0] bul_y_i,
  output logic               hit_valid_o,
  output logic [ID_W-1:0]    hit_id_o,
  output logic [HP_W-1:0]    hp_o,
  output logic               boom_o,
  output logic               revive_o,
  output logic               kill_o,
  output logic               blink_o
);

  localparam logic [HP_W-1:0]   HP_RST   = HP_W'(HP_MAX);
  localparam logic [TCNT_W-1:0] INV_TC   = TCNT_W'(INVULN_TICKS - 1);
  localparam logic [TCNT_W-1:0] DEATH_TC = TCNT_W'(DEATH_TICKS - 1);
  localparam logic [TCNT_W-1:0] RESP_TC  = TCNT_W'(RESPAWN_TICKS - 1);

  boss_state_t       state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              hit_valid_q, hit_d;
  logic [ID_W-1:0]   hit_id_q;
  logic              kill_q, kill_d;
  logic              revive_q, revive_d;
  logic              boom_q;
  logic              blink_q;
  logic              overlap;
  logic              hit_req;

  boss_hit_detect #(
    .BOSS_W (BOSS_W),
    .BOSS_H (BOSS_H),
    .BUL_W  (BUL_W),
    .BUL_H  (BUL_H)
  ) u_hit_detect (
    .boss_x_i  (boss_x_i),
    .boss_y_i  (boss_y_i),
    .bul_x_i   (bul_x_i),
    .bul_y_i   (bul_y_i),
    .overlap_o (overlap)
  );

  assign hit_req = bul_valid_i && overlap;

  // Next state, tick counter, hp and event pulses; a hit in ALIVE takes
  // priority over a coincident move_tick so the new state starts from tcnt=0.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    hp_d     = hp_q;
    hit_d    = 1'b0;
    kill_d   = 1'b0;
    revive_d = 1'b0;
    case (state_q)
      ALIVE: begin
        if (hit_req) begin
          hit_d  = 1'b1;
          tcnt_d = '0;
          if (hp_q <= HP_W'(1)) begin
            hp_d    = '0;
            kill_d  = 1'b1;
            state_d = DYING;
          end else begin
            hp_d    = hp_q - HP_W'(1);
            state_d = INVULN;
          end
        end else if (move_tick_i) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      INVULN: begin
        hit_d = hit_req;
        if (move_tick_i) begin
          if (tcnt_q == INV_TC) begin
            state_d = ALIVE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      DYING: begin
        if (move_tick_i) begin
          if (tcnt_q == DEATH_TC) begin
            state_d = DEAD;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      DEAD: begin
        if (move_tick_i) begin
          if (tcnt_q == RESP_TC) begin
            state_d  = ALIVE;
            tcnt_d   = '0;
            hp_d     = HP_RST;
            revive_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ALIVE;
        tcnt_d  = '0;
      end
    endcase
  end

  // State register; all outputs are registered from the next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ALIVE;
      tcnt_q      <= '0;
      hp_q        <= HP_RST;
      hit_valid_q <= 1'b0;
      hit_id_q    <= '0;
      kill_q      <= 1'b0;
      revive_q    <= 1'b0;
      boom_q      <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      hp_q        <= hp_d;
      hit_valid_q <= hit_d;
      if (hit_d) hit_id_q <= bul_id_i;
      kill_q      <= kill_d;
      revive_q    <= revive_d;
      boom_q      <= (state_d == DYING) || (state_d == DEAD);
      blink_q     <= (state_d == INVULN) && tcnt_d[1];
    end
  end

  assign hit_valid_o = hit_valid_q;
  assign hit_id_o    = hit_id_q;
  assign hp_o        = hp_q;
  assign boom_o      = boom_q;
  assign revive_o    = revive_q;
  assign kill_o      = kill_q;
  assign blink_o     = blink_q;

endmodule

// File: tb/tb_boss_hp_ctrl.sv
// Self-checking bench for boss_hp_ctrl: directed scenarios followed by a
// randomized phase, every cycle compared against a behavioural model.
module tb_boss_hp_ctrl;

  localparam int BOSS_W = 50;
  localparam int BOSS_H = 50;
  localparam int BUL_W  = 4;
  localparam int BUL_H  = 8;
  localparam int HP_MAX = 10;
  localparam int INV_T  = 8;
  localparam int DIE_T  = 64;
  localparam int RESP_T = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_tick;
  logic [9:0] boss_x, boss_y, bul_x, bul_y;
  logic       bul_valid;
  logic [3:0] bul_id;
  logic       hit_valid, boom, revive, kill, blink;
  logic [3:0] hit_id;
  logic [7:0] hp;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: hp, ticks seen since invulnerability began (-1 = not invulnerable),
  // ticks seen since the kill (-1 = not dead), and the last event outputs.
  int         m_hp, m_inv, m_dead;
  logic       m_hit, m_kill, m_rev;
  logic [3:0] m_id;

  boss_hp_ctrl #(
    .BOSS_W(BOSS_W), .BOSS_H(BOSS_H), .BUL_W(BUL_W), .BUL_H(BUL_H),
    .HP_MAX(HP_MAX), .INVULN_TICKS(INV_T), .DEATH_TICKS(DIE_T),
    .RESPAWN_TICKS(RESP_T)
  ) dut (
    .clk(clk), .rst(rst), .move_tick_i(move_tick),
    .boss_x_i(boss_x), .boss_y_i(boss_y),
    .bul_valid_i(bul_valid), .bul_id_i(bul_id),
    .bul_x_i(bul_x), .bul_y_i(bul_y),
    .hit_valid_o(hit_valid), .hit_id_o(hit_id), .hp_o(hp),
    .boom_o(boom), .revive_o(revive), .kill_o(kill), .blink_o(blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit overlaps(int bx, int by, int ux, int uy);
    return (ux + BUL_W > bx) && (ux < bx + BOSS_W) &&
           (uy + BUL_H > by) && (uy < by + BOSS_H);
  endfunction

  task automatic model_reset();
    m_hp = HP_MAX; m_inv = -1; m_dead = -1;
    m_hit = 1'b0; m_kill = 1'b0; m_rev = 1'b0; m_id = 4'd0;
  endtask

  task automatic model_step();
    bit hit;
    hit = bul_valid && overlaps(int'(boss_x), int'(boss_y), int'(bul_x), int'(bul_y));
    m_hit = 1'b0; m_kill = 1'b0; m_rev = 1'b0;
    if (m_dead >= 0) begin
      if (move_tick) begin
        m_dead++;
        if (m_dead == DIE_T + RESP_T) begin
          m_dead = -1; m_hp = HP_MAX; m_rev = 1'b1;
        end
      end
    end else if (m_inv >= 0) begin
      if (hit) begin m_hit = 1'b1; m_id = bul_id; end
      if (move_tick) begin
        m_inv++;
        if (m_inv == INV_T) m_inv = -1;
      end
    end else if (hit) begin
      m_hit = 1'b1; m_id = bul_id; m_hp--;
      if (m_hp == 0) begin m_kill = 1'b1; m_dead = 0; end
      else m_inv = 0;
    end
  endtask

  task automatic check_all();
    check("hit_valid", {7'd0, hit_valid}, {7'd0, m_hit});
    check("hit_id",    {4'd0, hit_id},    {4'd0, m_id});
    check("hp",        hp,                8'(m_hp));
    check("boom",      {7'd0, boom},      {7'd0, (m_dead >= 0)});
    check("revive",    {7'd0, revive},    {7'd0, m_rev});
    check("kill",      {7'd0, kill},      {7'd0, m_kill});
    check("blink",     {7'd0, blink},     {7'd0, (m_inv >= 0) && ((m_inv / 2) % 2 == 1)});
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare.
  task automatic step(input bit v, input int id, input int x, input int y, input bit tick);
    bul_valid = v; bul_id = 4'(id); bul_x = 10'(x); bul_y = 10'(y); move_tick = tick;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int tx, ty, guard;
    rst = 1'b1; move_tick = 1'b0; bul_valid = 1'b0; bul_id = 4'd0;
    bul_x = 10'd0; bul_y = 10'd0; boss_x = 10'd256; boss_y = 10'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_hp", hp, 8'd10);
    rst = 1'b0;

    // Edge cases around boss at (256,0)
    step(1, 3, 252, 10, 0);
    check("edge_left", {7'd0, hit_valid}, 8'd0);
    step(1, 4, 306, 10, 0);
    check("edge_right", {7'd0, hit_valid}, 8'd0);
    step(1, 5, 270, 20, 0);
    check("first_hit_hp", hp, 8'd9);
    check("first_hit_id", {4'd0, hit_id}, 8'd5);

    // Consecutive bullets while invulnerable: consumed, no damage
    for (int i = 0; i < 5; i++) step(1, 8 + i, 270, 20, 0);
    check("inv_hp", hp, 8'd9);
    for (int i = 0; i < INV_T; i++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
    end
    // Touching-edge-plus-one hit coincident with a tick
    step(1, 6, 253, 10, 1);
    check("edge_in_hp", hp, 8'd8);
    for (int i = 0; i < INV_T - 1; i++) step(0, 0, 0, 0, 1);
    step(1, 7, 260, 10, 0);
    check("inv_still_hp", hp, 8'd8);
    step(0, 0, 0, 0, 1);
    step(1, 2, 260, 10, 0);
    check("after_inv_hp", hp, 8'd7);

    // Grind to death and through respawn
    guard = 0;
    while (!m_rev && guard < 1500) begin
      step(1, guard % 16, 280, 30, 1);
      guard++;
    end
    check("respawn_reached", {7'd0, m_rev}, 8'd1);
    check("respawn_hp", hp, 8'd10);

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        boss_x = 10'($urandom_range(0, 900));
        boss_y = 10'($urandom_range(0, 900));
      end
      tx = int'(boss_x) + int'($urandom_range(0, 70)) - 10;
      ty = int'(boss_y) + int'($urandom_range(0, 70)) - 10;
      if (tx < 0) tx = 0;
      if (ty < 0) ty = 0;
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), tx, ty,
           $urandom_range(0, 2) == 0);
    end

    // Reset while dead
    boss_x = 10'd256; boss_y = 10'd0;
    guard = 0;
    while (m_dead < 70 && guard < 2000) begin
      step(1, 1, 270, 20, 1);
      guard++;
    end
    check("dead_reached", {7'd0, (m_dead >= 70)}, 8'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_boom", {7'd0, boom}, 8'd0);
    check("rst_dead_hp", hp, 8'd10);
    check_all();
    @(posedge clk);
    #3;
    rst = 1'b0;
    step(1, 9, 270, 20, 0);
    check("post_rst_hp", hp, 8'd9);
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
